// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register-address type, in-flight slot
// record and forwarding-select encoding.
package hazard_scoreboard_pkg;

    // Slot records store addresses at a fixed width so the struct can live here.
    // Narrower REG_AW values are zero-extended, which leaves equality compares intact.
    localparam int REG_AW_MAX = 8;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;
    typedef logic [2:0]            fwd_sel_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      rd_we;
        logic      is_load;
    } slot_t;

    localparam fwd_sel_t FWD_RF        = 3'd0;
    localparam fwd_sel_t FWD_SLOT_BASE = 3'd1;

endpackage

// File: rtl/hazard_scoreboard_hs_match.sv
// Per-source youngest-match priority encoder: turns the in-flight slots into a
// hazard flag and a forwarding select for one ID source operand.
module hs_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int FORWARD_EN = 1,
    parameter int WB_BYPASS  = 1
) (
    input  reg_addr_t src_i,
    input  logic      used_i,
    input  slot_t     slots_i [DEPTH],
    output logic      hazard_o,
    output fwd_sel_t  fwd_sel_o
);

    logic       found;
    logic       found_load;
    logic [2:0] k_idx;

    always_comb begin
        found      = 1'b0;
        found_load = 1'b0;
        k_idx      = '0;
        // Walk oldest to youngest so the last hit (smallest k) wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slots_i[i].valid && slots_i[i].rd_we && (slots_i[i].rd == src_i)) begin
                found      = 1'b1;
                found_load = slots_i[i].is_load;
                k_idx      = 3'(i);
            end
        end
        if (!used_i || (src_i == '0)) begin
            found = 1'b0;
        end

        hazard_o  = 1'b0;
        fwd_sel_o = FWD_RF;
        if (FORWARD_EN == 0) begin
            hazard_o = found && (int'(k_idx) < (DEPTH - WB_BYPASS));
        end else if (found) begin
            if ((k_idx == 3'd0) && found_load) begin
                hazard_o = 1'b1;
            end else if (!((WB_BYPASS != 0) && (int'(k_idx) == DEPTH - 1))) begin
                fwd_sel_o = FWD_SLOT_BASE + k_idx;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and flush controller beside ID: tracks in-flight writes EXE..WB, stalls
// on RAW hazards, selects forwarding, applies (possibly deferred) branch flushes.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int FORWARD_EN = 1,
    parameter int WB_BYPASS  = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              hold,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_clr,
    output logic              idexe_bubble,
    output logic [2:0]        fwd_sel_a,
    output logic [2:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic             pending_flush_q, pending_flush_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    reg_addr_t rs1_ext, rs2_ext;
    logic      hazard_a, hazard_b;
    fwd_sel_t  fwd_a, fwd_b;
    logic      stall, do_flush;

    assign rs1_ext = REG_AW_MAX'(id_rs1);
    assign rs2_ext = REG_AW_MAX'(id_rs2);

    hs_match #(.DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN), .WB_BYPASS(WB_BYPASS)) u_match_a (
        .src_i(rs1_ext), .used_i(id_rs1_used), .slots_i(slot_q),
        .hazard_o(hazard_a), .fwd_sel_o(fwd_a)
    );

    hs_match #(.DEPTH(DEPTH), .FORWARD_EN(FORWARD_EN), .WB_BYPASS(WB_BYPASS)) u_match_b (
        .src_i(rs2_ext), .used_i(id_rs2_used), .slots_i(slot_q),
        .hazard_o(hazard_b), .fwd_sel_o(fwd_b)
    );

    assign stall    = id_valid && (hazard_a || hazard_b);
    assign do_flush = (flush || pending_flush_q) && !hold;

    // Output priority: reset, hold, flush, stall, normal advance.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_clr     = 1'b0;
        idexe_bubble = 1'b0;
        fwd_sel_a    = fwd_a;
        fwd_sel_b    = fwd_b;
        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_clr     = 1'b1;
            idexe_bubble = 1'b1;
            fwd_sel_a    = FWD_RF;
            fwd_sel_b    = FWD_RF;
        end else if (hold) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (do_flush) begin
            ifid_clr     = 1'b1;
            idexe_bubble = 1'b1;
        end else if (stall) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idexe_bubble = 1'b1;
        end
    end

    always_comb begin
        slot_d = slot_q;
        if (!hold) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0] = '0;
            if (id_valid && !stall && !do_flush) begin
                slot_d[0] = '{valid: 1'b1, rd: REG_AW_MAX'(id_rd),
                              rd_we: id_rd_we, is_load: id_is_load};
            end
        end

        pending_flush_d = pending_flush_q;
        if (do_flush) begin
            pending_flush_d = 1'b0;
        end else if (flush && hold) begin
            pending_flush_d = 1'b1;
        end

        // A flush cycle is never counted, even when it overrides a stall.
        stall_cnt_d = stall_cnt_q;
        if ((hold || (stall && !do_flush)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            pending_flush_q <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            slot_q          <= slot_d;
            pending_flush_q <= pending_flush_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
